// File: rtl/prbs15_checker.sv
// PRBS15 (x^15 + x^14 + 1) serial checker: self-syncs, locks after LOCK_THRESH good predictions, counts bit errors while locked.
// Latency: all outputs registered; err_o/err_count_o reflect a valid bit one cycle after it is sampled.
// Backpressure: none; accepts one bit per cycle when valid_i is high. PRBS15_CHK_BITCNT_EN adds the 32-bit bit counter.
module prbs15_checker #(
    parameter int LOCK_THRESH   = 32,
    parameter int WINDOW        = 64,
    parameter int UNLOCK_THRESH = 8,
    parameter int ERR_W         = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             prbs_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_count_o,
    output logic [31:0]      bit_count_o
);

    typedef enum logic [1:0] {ACQUIRE, VERIFY, LOCKED} state_t;

    state_t             state_q, state_d;
    logic [14:0]        hist_q, hist_d;
    logic [3:0]         fill_q, fill_d;
    logic [7:0]         run_q, run_d;
    logic [8:0]         win_cnt_q, win_cnt_d;
    logic [8:0]         win_err_q, win_err_d;
    logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
    logic               err_q, err_d;
    logic               locked_q;

    logic               pred;
    logic               mismatch;
    logic [14:0]        rx_hist;
    logic [7:0]         run_inc;
    logic [8:0]         win_cnt_inc;
    logic [8:0]         win_err_inc;

    assign pred        = hist_q[14] ^ hist_q[13];
    assign mismatch    = prbs_i ^ pred;
    assign rx_hist     = {hist_q[13:0], prbs_i};
    assign run_inc     = run_q + 8'd1;
    assign win_cnt_inc = win_cnt_q + 9'd1;
    assign win_err_inc = win_err_q + {8'd0, mismatch};

    // Next-state and datapath decode; everything holds unless a valid bit arrives.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        run_d     = run_q;
        win_cnt_d = win_cnt_q;
        win_err_d = win_err_q;
        err_cnt_d = err_cnt_q;
        err_d     = 1'b0;
        if (valid_i) begin
            case (state_q)
                ACQUIRE: begin
                    hist_d = rx_hist;
                    if (fill_q == 4'd14) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end
                VERIFY: begin
                    // Self-sync: the received bit feeds the history. An all-zero
                    // history would predict zeros forever, so it never builds a run.
                    hist_d = rx_hist;
                    if (mismatch || (rx_hist == '0)) begin
                        run_d = '0;
                    end else if (run_inc == 8'(LOCK_THRESH)) begin
                        state_d   = LOCKED;
                        run_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                LOCKED: begin
                    // Flywheel: the local prediction feeds the history so line
                    // errors cannot corrupt the reference sequence.
                    hist_d = {hist_q[13:0], pred};
                    if (mismatch) begin
                        err_d = 1'b1;
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                    end
                    if (win_err_inc == 9'(UNLOCK_THRESH)) begin
                        state_d   = ACQUIRE;
                        fill_d    = '0;
                        run_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_inc == 9'(WINDOW)) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_inc;
                        win_err_d = win_err_inc;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end
        if (clear_i) begin
            err_cnt_d = '0;
        end
    end

    // State, history, counters and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ACQUIRE;
            hist_q    <= '0;
            fill_q    <= '0;
            run_q     <= '0;
            win_cnt_q <= '0;
            win_err_q <= '0;
            err_cnt_q <= '0;
            err_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            run_q     <= run_d;
            win_cnt_q <= win_cnt_d;
            win_err_q <= win_err_d;
            err_cnt_q <= err_cnt_d;
            err_q     <= err_d;
            locked_q  <= (state_d == LOCKED);
        end
    end

    assign locked_o    = locked_q;
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

`ifdef PRBS15_CHK_BITCNT_EN
    logic [31:0] bit_cnt_q;
    logic        cnt_bit;

    assign cnt_bit = valid_i && (state_q == LOCKED);

    // Saturating count of bits checked while locked; clear wins over increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
        end else if (clear_i) begin
            bit_cnt_q <= '0;
        end else if (cnt_bit && (bit_cnt_q != 32'hFFFF_FFFF)) begin
            bit_cnt_q <= bit_cnt_q + 32'd1;
        end
    end

    assign bit_count_o = bit_cnt_q;
`else
    assign bit_count_o = '0;
`endif

endmodule

// File: tb/tb_prbs15_checker.sv
// Directed bench for prbs15_checker: lock, single/burst errors, clear, async reset, all-zero input, sparse valid.
// Expected values come from a local PRBS15 generator and hand-derived counts.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_prbs15_checker;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        prbs_i  = 1'b0;
    logic        valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o;
    logic        err_o;
    logic [15:0] err_count_o;
    logic [31:0] bit_count_o;

    int          n_cmp       = 0;
    int          n_fail      = 0;
    int          lk_bits     = 0;
    int          bc_exp      = 0;
    int          n_err_pulse = 0;
    int          n_lk_seen   = 0;
    int          first_lock  = 0;
    int          pad         = 0;
    bit          exp_lk      = 1'b0;
    logic [14:0] g           = 15'h0001;
    logic        b;

`ifdef PRBS15_CHK_BITCNT_EN
    localparam bit BC_EN = 1'b1;
`else
    localparam bit BC_EN = 1'b0;
`endif

    prbs15_checker #(
        .LOCK_THRESH  (32),
        .WINDOW       (64),
        .UNLOCK_THRESH(8),
        .ERR_W        (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .prbs_i     (prbs_i),
        .valid_i    (valid_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .err_o      (err_o),
        .err_count_o(err_count_o),
        .bit_count_o(bit_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gen_next(output logic bit_o);
        bit_o = g[14] ^ g[13];
        g     = {g[13:0], bit_o};
    endtask

    task automatic drive(input logic bit_i, input logic v, input logic clr);
        prbs_i  = bit_i;
        valid_i = v;
        clear_i = clr;
        @(posedge clk_i);
        #1;
        if (err_o) n_err_pulse++;
        if (v && exp_lk) lk_bits++;
        if (clr) bc_exp = 0;
        else if (v && exp_lk) bc_exp++;
        valid_i = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic send_clean(input int n);
        logic x;
        for (int i = 0; i < n; i++) begin
            gen_next(x);
            drive(x, 1'b1, 1'b0);
        end
    endtask

    task automatic send_clean3(input int n);
        logic x;
        for (int i = 0; i < n; i++) begin
            gen_next(x);
            drive(x, 1'b1, 1'b0);
            drive(1'($urandom), 1'b0, 1'b0);
            drive(1'($urandom), 1'b0, 1'b0);
        end
    endtask

    task automatic send_err(input logic clr);
        logic x;
        gen_next(x);
        drive(~x, 1'b1, clr);
    endtask

    task automatic pulse_reset();
        #2 rst_i = 1'b1;
        exp_lk = 1'b0;
        bc_exp = 0;
        lk_bits = 0;
        @(posedge clk_i);
        #3 rst_i = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_errcnt", 32'(err_count_o), 32'd0);
        chk("rst_bitcnt", bit_count_o, 32'd0);
        #2 rst_i = 1'b0;

        // Lock boundary: 15 fill + 32 matches
        send_clean(46);
        chk("lock_46", 32'(locked_o), 32'd0);
        send_clean(1);
        chk("lock_47", 32'(locked_o), 32'd1);
        exp_lk = 1'b1;

        // Long clean run
        n_err_pulse = 0;
        send_clean(10000);
        chk("clean_pulses", 32'(n_err_pulse), 32'd0);
        chk("clean_errcnt", 32'(err_count_o), 32'd0);
        chk("clean_bitcnt", bit_count_o, BC_EN ? 32'(bc_exp) : 32'd0);
        chk("clean_locked", 32'(locked_o), 32'd1);

        // Single error
        send_err(1'b0);
        chk("err1_pulse", 32'(err_o), 32'd1);
        chk("err1_errcnt", 32'(err_count_o), 32'd1);
        chk("err1_locked", 32'(locked_o), 32'd1);
        n_err_pulse = 0;
        send_clean(1000);
        chk("err1_after_pulses", 32'(n_err_pulse), 32'd0);
        chk("err1_after_errcnt", 32'(err_count_o), 32'd1);
        chk("err1_after_locked", 32'(locked_o), 32'd1);

        // Clear coincident with an error: pulse still fires, counts zeroed
        send_err(1'b1);
        chk("clr_pulse", 32'(err_o), 32'd1);
        chk("clr_errcnt", 32'(err_count_o), 32'd0);
        chk("clr_bitcnt", bit_count_o, 32'd0);

        // Burst of 8 errors inside one aligned window
        pad = (64 - (lk_bits % 64)) % 64;
        send_clean(pad);
        for (int i = 0; i < 7; i++) begin
            send_err(1'b0);
            send_clean(1);
        end
        chk("burst7_locked", 32'(locked_o), 32'd1);
        chk("burst7_errcnt", 32'(err_count_o), 32'd7);
        send_err(1'b0);
        chk("burst8_locked", 32'(locked_o), 32'd0);
        chk("burst8_pulse", 32'(err_o), 32'd1);
        chk("burst8_errcnt", 32'(err_count_o), 32'd8);
        chk("burst8_bitcnt", bit_count_o, BC_EN ? 32'(bc_exp) : 32'd0);
        exp_lk = 1'b0;

        // Relock after loss of lock
        send_clean(46);
        chk("relock_46", 32'(locked_o), 32'd0);
        chk("relock_errcnt", 32'(err_count_o), 32'd8);
        send_clean(1);
        chk("relock_47", 32'(locked_o), 32'd1);
        exp_lk = 1'b1;

        // Build err_count = 5, then async reset mid-lock
        gen_next(b);
        drive(b, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_err(1'b0);
            send_clean(10);
        end
        chk("pre_rst_errcnt", 32'(err_count_o), 32'd5);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_locked", 32'(locked_o), 32'd0);
        chk("async_rst_err", 32'(err_o), 32'd0);
        chk("async_rst_errcnt", 32'(err_count_o), 32'd0);
        chk("async_rst_bitcnt", bit_count_o, 32'd0);
        exp_lk = 1'b0;
        bc_exp = 0;
        lk_bits = 0;
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        send_clean(46);
        chk("rst_relock_46", 32'(locked_o), 32'd0);
        send_clean(1);
        chk("rst_relock_47", 32'(locked_o), 32'd1);

        // All-zero stream never locks; a real sequence then locks within 47 bits
        pulse_reset();
        n_lk_seen = 0;
        for (int i = 0; i < 500; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            if (locked_o) n_lk_seen++;
        end
        chk("zero_never_lock", 32'(n_lk_seen), 32'd0);
        chk("zero_errcnt", 32'(err_count_o), 32'd0);
        g = 15'h0001;
        first_lock = 0;
        for (int i = 1; i <= 47; i++) begin
            send_clean(1);
            if (locked_o && (first_lock == 0)) first_lock = i;
        end
        chk("zero_then_lock_le47", 32'((first_lock >= 1) && (first_lock <= 47)), 32'd1);

        // Sparse valid (1 of 3 cycles): counts are in valid bits only
        pulse_reset();
        send_clean3(46);
        chk("sparse_lock_46", 32'(locked_o), 32'd0);
        send_clean3(1);
        chk("sparse_lock_47", 32'(locked_o), 32'd1);
        exp_lk = 1'b1;
        send_clean3(30);
        chk("sparse_bitcnt30", bit_count_o, BC_EN ? 32'd30 : 32'd0);
        send_err(1'b0);
        chk("sparse_err_pulse", 32'(err_o), 32'd1);
        chk("sparse_errcnt", 32'(err_count_o), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        chk("sparse_err_low", 32'(err_o), 32'd0);
        chk("sparse_errcnt_hold", 32'(err_count_o), 32'd1);
        chk("sparse_bitcnt31", bit_count_o, BC_EN ? 32'd31 : 32'd0);
        chk("sparse_locked", 32'(locked_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs15_checker.md
# prbs15_checker

Serial PRBS15 (x^15 + x^14 + 1) receiver/checker, the far end of the team's PRBS15 generator. Self-synchronises to an incoming bit stream, declares lock after a run of correct predictions, then free-runs its local copy of the sequence and counts bit errors for BER measurement. Sits on the loopback/test path, fed by the serial output of the generator or by a link under test.

## Interface
Parameters:
- LOCK_THRESH, 32, consecutive correct predictions in VERIFY needed to lock (1..255)
- WINDOW, 64, loss-of-lock observation window in valid bits (2..256)
- UNLOCK_THRESH, 8, errors within one window that force unlock (1..WINDOW)
- ERR_W, 16, width of error counter

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- prbs_i  in  1  received serial bit
- valid_i  in  1  prbs_i is sampled only when high
- clear_i  in  1  synchronous clear of err_count_o and bit_count_o
- locked_o  out  1  checker is in LOCKED
- err_o  out  1  one-cycle pulse per detected bit error while locked
- err_count_o  out  ERR_W  saturating error count
- bit_count_o  out  32  saturating count of bits checked while locked (see Configuration)

## Operation
- History register h[14:0]; h[14] oldest, h[0] newest. Predicted bit p = h[14] ^ h[13]. Every valid bit shifts h <= {h[13:0], x}.
- States: ACQUIRE, VERIFY, LOCKED. Reset state ACQUIRE, h = 0, all counters 0.
- ACQUIRE: x = prbs_i; fill counter counts valid bits; on the 15th goes to VERIFY with run = 0.
- VERIFY: x = prbs_i (self-sync). Match (prbs_i == p) increments run; mismatch sets run = 0 and stays in VERIFY. If the new h is all zero, run = 0 (all-zero stream never locks). When run reaches LOCK_THRESH, goes to LOCKED; window counters cleared.
- LOCKED: x = p (flywheel; received errors do not corrupt h). Mismatch -> err_o pulse, err_count_o += 1 (saturate at 2^ERR_W-1), win_err += 1. Each valid bit: bit_count_o += 1 (saturate at 2^32-1), win_cnt += 1.
- Loss of lock: when win_err including the current bit reaches UNLOCK_THRESH, go to ACQUIRE on that edge (fill counter 0, run 0). When win_cnt completes WINDOW bits without unlock, win_cnt and win_err reset to 0.
- Only LOCKED bits contribute to err_count_o/bit_count_o; the bit that causes lock is not counted.
- clear_i: zeroes err_count_o and bit_count_o; takes priority over a simultaneous increment (that bit not counted). Does not affect state, h, run or window counters.
- valid_i low: nothing changes; err_o low.

## Timing
- All outputs registered. Reset values: locked_o 0, err_o 0, err_count_o 0, bit_count_o 0.
- err_o high exactly in the cycle after the clock edge that sampled the erroneous valid bit; err_count_o updates on that same edge.
- locked_o rises on the edge that samples the LOCK_THRESH-th consecutive match; from clean reset with a valid stream every cycle, locked_o is high after 15 + LOCK_THRESH valid bits.
- locked_o falls on the edge that samples the UNLOCK_THRESH-th windowed error; that bit still pulses err_o and is counted.
- rst_i asserted mid-operation: all state and outputs return to reset values immediately (asynchronously), no partial count retained.
- Throughput: one bit per cycle; no back-pressure.

## Configuration
- PRBS15_CHK_BITCNT_EN defined: 32-bit bit counter implemented as above.
- Not defined: counter omitted, bit_count_o tied to 0; all other behaviour identical.

## Test plan
- Generator seeded 15'h0001, valid every cycle -> locked_o high after 47 bits, err_count_o stays 0 over 10000 bits, bit_count_o = bits since lock.
- After lock, invert one bit -> exactly one err_o pulse, err_count_o = 1, locked_o stays 1, next 1000 bits error-free.
- After lock, invert 8 bits within 64 -> locked_o drops on the 8th error, err_count_o = 8; clean stream relocks after 47 further bits.
- All-zero input for 500 bits -> locked_o never asserts; then valid sequence -> locks within 47 bits of its start.
- valid_i toggling 1-of-3 cycles -> identical lock/error results counted in valid bits only; clear_i coincident with an error -> err_count_o = 0, err_o still pulses.
- rst_i pulsed asynchronously mid-lock with err_count_o = 5 -> all outputs 0 immediately, relock after 47 bits.
